pipe_ctrl: RTL and testbench

- Pipeline control and condition-code unit for the 5-stage Y86-64 core.
- Detects load-use, ret and branch-mispredict hazards and drives stall/bubble to F/D/E/M/W pipeline registers.
- Owns the architectural CC register (OF,SF,ZF) fed by the execute-stage ALU flags; gates set_cc on exceptions.
- Runs a RUN/DRAIN/HALTED FSM that freezes the machine after HLT/ADR/INS reaches writeback.

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/pipe_ctrl_hazard.sv | 30 +++
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, one-hot status codes, register IDs,
// condition-code layout and the pipeline-control state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status is one-hot, MSB first: AOK, HLT, ADR, INS
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam int unsigned CC_OF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_ZF = 0;
    localparam logic [2:0]  CC_RESET = 3'b001;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } ctrl_state_e;

    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational hazard detection for the Y86-64 pipeline:
// load-use, pending return and branch mispredict.
module pipe_hazard_detect
    import y86_pkg::*;
#(
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_destM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    output logic       load_use,
    output logic       ret_pend,
    output logic       mispredict
);

    // RNONE as a load destination never creates a dependency, even if a
    // decode source is also RNONE.
    assign load_use = is_mem_load(E_icode) && (E_destM != RNONE) &&
                      ((E_destM == d_srcA) || (E_destM == d_srcB));

    assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) ||
                      (M_icode == I_RET);

    assign mispredict = (E_icode == I_JXX) && !e_Cnd;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, CC register and the
// RUN/DRAIN/HALTED FSM. Optional counters via PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_destM,
    input  logic             e_Cnd,
    input  logic             e_of,
    input  logic             e_sf,
    input  logic             e_zf,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [2:0]       cc,
    output logic             halted,
    output logic [3:0]       exc_stat
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] mispred_cnt
`endif
);

    ctrl_state_e state, state_nxt;

    logic load_use;
    logic ret_pend;
    logic mispredict;
    logic exc_m;
    logic exc_w;

    pipe_hazard_detect #(
        .RNONE (RNONE)
    ) u_hazard (
        .D_icode    (D_icode),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .E_icode    (E_icode),
        .E_destM    (E_destM),
        .e_Cnd      (e_Cnd),
        .M_icode    (M_icode),
        .load_use   (load_use),
        .ret_pend   (ret_pend),
        .mispredict (mispredict)
    );

    assign exc_m  = (m_stat != STAT_AOK);
    assign exc_w  = (W_stat != STAT_AOK);
    assign halted = (state == ST_HALTED);

    always_comb begin
        state_nxt = state;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        set_cc    = 1'b0;
        unique case (state)
            ST_RUN, ST_DRAIN: begin
                F_stall  = load_use | ret_pend;
                D_stall  = load_use;
                // A load-use stall in D takes priority over the ret bubble
                D_bubble = mispredict | (ret_pend & ~load_use);
                E_bubble = mispredict | load_use;
                M_bubble = exc_m | exc_w;
                W_stall  = exc_w;
                set_cc   = (E_icode == I_OPQ) & ~exc_m & ~exc_w &
                           (state == ST_RUN);
                if (exc_w) begin
                    state_nxt = ST_HALTED;
                end else if (exc_m && state == ST_RUN) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (set_cc) begin
            cc[CC_OF] <= e_of;
            cc[CC_SF] <= e_sf;
            cc[CC_ZF] <= e_zf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_stat <= STAT_AOK;
        end else if (state != ST_HALTED && state_nxt == ST_HALTED) begin
            exc_stat <= W_stat;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters wrap naturally and stop once the machine has halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            bubble_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (state != ST_HALTED) begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
            if (D_bubble | E_bubble) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, hand sequences for
// reset/ret/CC/exception corners, and randomized traffic against a model.
module tb_pipe_ctrl;

    localparam int unsigned TB_CNT_W = 4;
    localparam logic [3:0]  AOK = 4'b1000;
    localparam logic [3:0]  HLT = 4'b0100;
    localparam logic [3:0]  ADR = 4'b0010;
    localparam logic [3:0]  INS = 4'b0001;

    logic       clk;
    logic       rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode;
    logic       e_Cnd, e_of, e_sf, e_zf;
    logic [3:0] m_stat, W_stat;
    logic       F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
    logic       set_cc, halted;
    logic [2:0] cc;
    logic [3:0] exc_stat;
`ifdef PIPE_CTRL_PERF_EN
    logic [TB_CNT_W-1:0] cyc_cnt, bubble_cnt, mispred_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(
        .CNT_W (TB_CNT_W),
        .RNONE (4'hF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_destM  (E_destM),
        .e_Cnd    (e_Cnd),
        .e_of     (e_of),
        .e_sf     (e_sf),
        .e_zf     (e_zf),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .W_stall  (W_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .M_bubble (M_bubble),
        .set_cc   (set_cc),
        .cc       (cc),
        .halted   (halted),
        .exc_stat (exc_stat)
`ifdef PIPE_CTRL_PERF_EN
       ,.cyc_cnt     (cyc_cnt),
        .bubble_cnt  (bubble_cnt),
        .mispred_cnt (mispred_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic fs, ds, ws, db, eb, mb, scc, mp;
    } pred_t;

    bit          m_halted;
    bit          m_drain;
    logic [2:0]  m_cc;
    logic [3:0]  m_exc;
    int unsigned m_cyc, m_bub, m_mis;

    function automatic pred_t predict();
        pred_t p;
        bit lu, rp, mp, em, ew;
        lu = (E_icode inside {4'h5, 4'hB}) && E_destM != 4'hF &&
             (E_destM == d_srcA || E_destM == d_srcB);
        rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp = (E_icode == 4'h7) && !e_Cnd;
        em = (m_stat != AOK);
        ew = (W_stat != AOK);
        if (m_halted) begin
            p = '{fs: 1, ds: 1, ws: 1, db: 0, eb: 0, mb: 0, scc: 0, mp: 0};
        end else begin
            p.fs  = lu || rp;
            p.ds  = lu;
            p.db  = mp || (rp && !lu);
            p.eb  = mp || lu;
            p.mb  = em || ew;
            p.ws  = ew;
            p.scc = (E_icode == 4'h6) && !em && !ew && !m_drain;
            p.mp  = mp;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_halted = 0;
        m_drain  = 0;
        m_cc     = 3'b001;
        m_exc    = AOK;
        m_cyc    = 0;
        m_bub    = 0;
        m_mis    = 0;
    endtask

    task automatic model_step();
        pred_t p;
        p = predict();
        if (!m_halted) begin
            if (p.scc) m_cc = {e_of, e_sf, e_zf};
            m_cyc = (m_cyc + 1) % (1 << TB_CNT_W);
            if (p.db || p.eb) m_bub = (m_bub + 1) % (1 << TB_CNT_W);
            if (p.mp) m_mis = (m_mis + 1) % (1 << TB_CNT_W);
            if (W_stat != AOK) begin
                m_halted = 1;
                m_exc    = W_stat;
            end else if (m_stat != AOK) begin
                m_drain = 1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        pred_t p;
        p = predict();
        chk("F_stall", F_stall, p.fs);
        chk("D_stall", D_stall, p.ds);
        chk("W_stall", W_stall, p.ws);
        chk("D_bubble", D_bubble, p.db);
        chk("E_bubble", E_bubble, p.eb);
        chk("M_bubble", M_bubble, p.mb);
        chk("set_cc", set_cc, p.scc);
        chk("cc", cc, m_cc);
        chk("halted", halted, m_halted);
        chk("exc_stat", exc_stat, m_exc);
`ifdef PIPE_CTRL_PERF_EN
        chk("cyc_cnt", cyc_cnt, m_cyc);
        chk("bubble_cnt", bubble_cnt, m_bub);
        chk("mispred_cnt", mispred_cnt, m_mis);
`endif
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic cycle();
        #2;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_destM = 4'hF; e_Cnd = 1'b1;
        e_of = 1'b0; e_sf = 1'b0; e_zf = 1'b0;
        M_icode = 4'h1; m_stat = AOK; W_stat = AOK;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_cc", cc, 3'b001);
        chk("rst_halted", halted, 1'b0);
        chk("rst_exc_stat", exc_stat, 4'b1000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] pick_reg();
        int unsigned r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    function automatic logic [3:0] pick_stat(input int unsigned one_in);
        logic [3:0] bad [3];
        bad[0] = HLT; bad[1] = ADR; bad[2] = INS;
        if ($urandom_range(1, one_in) == 1) return bad[$urandom_range(0, 2)];
        return AOK;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] di, sa, sb, ei, ed;
        logic       cnd;
        logic [3:0] mi;
        logic       fs, ds, db, eb;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 1, 1, 0, 1};
        vecs[1] = '{4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 0, 0, 0, 0};
        vecs[2] = '{4'h1, 4'h0, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 1, 1, 0, 1};
        vecs[3] = '{4'h1, 4'h3, 4'h3, 4'h6, 4'h3, 1'b1, 4'h1, 0, 0, 0, 0};
        vecs[4] = '{4'h9, 4'h4, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 1, 0, 1, 0};
        vecs[5] = '{4'h1, 4'h2, 4'h7, 4'h5, 4'h2, 1'b1, 4'h9, 1, 1, 0, 1};
        vecs[6] = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 0, 0, 1, 1};
        vecs[7] = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 0, 0, 0, 0};
        vecs[8] = '{4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 1, 0, 1, 1};
        vecs[9] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 1'b1, 4'h9, 1, 0, 1, 0};

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            D_icode = vecs[i].di; d_srcA = vecs[i].sa; d_srcB = vecs[i].sb;
            E_icode = vecs[i].ei; E_destM = vecs[i].ed; e_Cnd = vecs[i].cnd;
            M_icode = vecs[i].mi;
            #1;
            chk($sformatf("vec%0d_F_stall", i), F_stall, vecs[i].fs);
            chk($sformatf("vec%0d_D_stall", i), D_stall, vecs[i].ds);
            chk($sformatf("vec%0d_D_bubble", i), D_bubble, vecs[i].db);
            chk($sformatf("vec%0d_E_bubble", i), E_bubble, vecs[i].eb);
            cycle();
        end

        // Ret walking down the pipe: 3 cycles of stall+bubble, clear on 4th
        idle_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            D_icode = (i == 0) ? 4'h9 : 4'h1;
            E_icode = (i == 1) ? 4'h9 : 4'h1;
            M_icode = (i == 2) ? 4'h9 : 4'h1;
            #1;
            chk($sformatf("ret%0d_F_stall", i), F_stall, (i < 3) ? 1'b1 : 1'b0);
            chk($sformatf("ret%0d_D_bubble", i), D_bubble, (i < 3) ? 1'b1 : 1'b0);
            cycle();
        end

        // CC write from OPQ, visible the following cycle
        idle_inputs();
        E_icode = 4'h6; e_of = 1'b0; e_sf = 1'b1; e_zf = 1'b0;
        #1;
        chk("cc_set_cc", set_cc, 1'b1);
        cycle();
        idle_inputs();
        #1;
        chk("cc_value", cc, 3'b010);
        cycle();

        // Exception in M -> DRAIN, then in W -> HALTED
        E_icode = 4'h6; e_of = 1'b1; e_sf = 1'b1; e_zf = 1'b1; m_stat = HLT;
        #1;
        chk("exc_m_set_cc", set_cc, 1'b0);
        chk("exc_m_M_bubble", M_bubble, 1'b1);
        cycle();
        chk("drain_halted", halted, 1'b0);
        m_stat = AOK; W_stat = HLT;
        #1;
        chk("drain_set_cc", set_cc, 1'b0);
        chk("drain_W_stall", W_stall, 1'b1);
        cycle();
        W_stat = AOK;
        #1;
        chk("halt_halted", halted, 1'b1);
        chk("halt_exc_stat", exc_stat, 4'b0100);
        chk("halt_F_stall", F_stall, 1'b1);
        chk("halt_D_stall", D_stall, 1'b1);
        chk("halt_W_stall", W_stall, 1'b1);
        chk("halt_E_bubble", E_bubble, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("halt_cc_frozen", cc, 3'b010);

        // Asynchronous reset mid-cycle with a load-use hazard present
        E_icode = 4'h5; E_destM = 4'h3; d_srcA = 4'h3;
        #2;
        do_reset();
        #1;
        chk("post_rst_F_stall", F_stall, 1'b1);
        chk("post_rst_D_stall", D_stall, 1'b1);
        chk("post_rst_E_bubble", E_bubble, 1'b1);
        chk("post_rst_D_bubble", D_bubble, 1'b0);
        #1;
        cycle();

`ifdef PIPE_CTRL_PERF_EN
        idle_inputs();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            e_Cnd = (i == 3 || i == 7) ? 1'b0 : 1'b1;
            E_icode = (i == 3 || i == 7) ? 4'h7 : 4'h1;
            cycle();
        end
        chk("perf_cyc", cyc_cnt, 10);
        chk("perf_mis", mispred_cnt, 2);
        chk("perf_bub", bubble_cnt, 2);
        idle_inputs();
        for (int i = 0; i < 6; i++) cycle();
        chk("perf_wrap", cyc_cnt, 0);
`endif

        // Randomized traffic against the model
        idle_inputs();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (m_halted && $urandom_range(0, 5) == 0) begin
                idle_inputs();
                do_reset();
            end
            D_icode = 4'($urandom_range(0, 11));
            E_icode = 4'($urandom_range(0, 11));
            M_icode = 4'($urandom_range(0, 11));
            d_srcA  = pick_reg();
            d_srcB  = pick_reg();
            E_destM = pick_reg();
            e_Cnd   = 1'($urandom_range(0, 1));
            e_of    = 1'($urandom_range(0, 1));
            e_sf    = 1'($urandom_range(0, 1));
            e_zf    = 1'($urandom_range(0, 1));
            m_stat  = pick_stat(20);
            W_stat  = pick_stat(30);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
